dbg_bus_master: RTL and testbench

Hardware initiator for the MIPS debug bus: drives `MOSI`/`SPI_cs`/`SCLK`/`valid`/`continue` and samples `MISO` with fixed, parameterised timing. It replaces software bit-banging of the GPIO port. It sits between a request/response command source (UART bridge or test sequencer) and the `Mips` debug inputs, on the 50 MHz application clock.

---
 rtl/dbg_bus_master.sv | 142 ++++++++++++++
 tb/tb_dbg_bus_master.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_bus_master.sv
// MIPS debug-bus initiator: SETUP/PULSE/HOLD strobe sequencing, MISO capture (DBG_BUS_MASTER_MISO_SYNC_EN adds a 2-flop MISO synchroniser).
// Latency: response valid SETUP_CYC+PULSE_CYC+HOLD_CYC edges after acceptance (HOLD_CYC for CONT ops).
// Backpressure: one command in flight; response held until i_rsp_ready, requests accepted only in IDLE.
module dbg_bus_master #(
    parameter int NB_BITS   = 32,
    parameter int NB_MOSI   = 25,
    parameter int NB_CS     = 4,
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req_valid,
    input  logic [1:0]         i_req_op,
    input  logic [NB_CS-1:0]   i_req_cs,
    input  logic [NB_MOSI-1:0] i_req_data,
    output logic               o_req_ready,
    output logic               o_rsp_valid,
    output logic [NB_BITS-1:0] o_rsp_data,
    input  logic               i_rsp_ready,
    output logic [NB_MOSI-1:0] o_MOSI,
    output logic [NB_CS-1:0]   o_SPI_cs,
    output logic               o_SCLK,
    output logic               o_valid,
    output logic               o_continue,
    input  logic [NB_BITS-1:0] i_MISO
);
    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, RESP} state_t;

    localparam logic [1:0] OP_XFER = 2'b00;
    localparam logic [1:0] OP_STEP = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;

    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

    state_t             state;
    logic [7:0]         cnt;
    logic [1:0]         op_q;
    logic [NB_BITS-1:0] miso_cap;

`ifdef DBG_BUS_MASTER_MISO_SYNC_EN
    logic [NB_BITS-1:0] miso_s1, miso_s2;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            miso_s1 <= '0;
            miso_s2 <= '0;
        end else begin
            miso_s1 <= i_MISO;
            miso_s2 <= miso_s1;
        end
    end

    assign miso_cap = miso_s2;

    // The synchroniser needs the hold window to cover its two-cycle delay.
    if (HOLD_CYC < 3) begin : g_hold_chk
        $error("HOLD_CYC must be >= 3 with the MISO synchroniser");
    end
`else
    assign miso_cap = i_MISO;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            op_q        <= OP_XFER;
            o_req_ready <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_MOSI      <= '0;
            o_SPI_cs    <= '0;
            o_SCLK      <= 1'b0;
            o_valid     <= 1'b0;
            o_continue  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!o_req_ready) begin
                        o_req_ready <= 1'b1;
                    end else if (i_req_valid) begin
                        o_req_ready <= 1'b0;
                        op_q        <= i_req_op;
                        if (i_req_op == OP_XFER || i_req_op == OP_STEP) begin
                            o_SPI_cs <= (i_req_op == OP_XFER) ? i_req_cs : '0;
                            o_MOSI   <= i_req_data;
                            cnt      <= SETUP_LD;
                            state    <= SETUP;
                        end else begin
                            o_continue <= (i_req_op == OP_SET);
                            cnt        <= HOLD_LD;
                            state      <= HOLD;
                        end
                    end
                end
                SETUP: begin
                    if (cnt == 8'd0) begin
                        if (op_q == OP_XFER) o_SCLK  <= 1'b1;
                        else                 o_valid <= 1'b1;
                        cnt   <= PULSE_LD;
                        state <= PULSE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                PULSE: begin
                    if (cnt == 8'd0) begin
                        o_SCLK  <= 1'b0;
                        o_valid <= 1'b0;
                        cnt     <= HOLD_LD;
                        state   <= HOLD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 8'd0) begin
                        o_rsp_data  <= miso_cap;
                        o_rsp_valid <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_SPI_cs    <= '0;
                        o_MOSI      <= '0;
                        o_req_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dbg_bus_master.sv
// Directed bench for dbg_bus_master: reset, XFER, STEP, CONT, back-pressure and MISO capture timing.
module tb_dbg_bus_master;
    localparam int S = 2;
    localparam int P = 2;
`ifdef DBG_BUS_MASTER_MISO_SYNC_EN
    localparam int H = 3;
`else
    localparam int H = 2;
`endif
    localparam int L    = S + P + H;
    localparam int NOBS = L + 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [3:0]  req_cs = 4'h0;
    logic [24:0] req_data = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_ready = 1'b0;
    logic [24:0] mosi;
    logic [3:0]  spi_cs;
    logic        sclk;
    logic        strobe_valid;
    logic        cont;
    logic [31:0] miso = '0;

    always #5 clk = ~clk;

    dbg_bus_master #(
        .NB_BITS(32), .NB_MOSI(25), .NB_CS(4),
        .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)
    ) dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_req_valid(req_valid), .i_req_op(req_op), .i_req_cs(req_cs), .i_req_data(req_data),
        .o_req_ready(req_ready), .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .i_rsp_ready(rsp_ready),
        .o_MOSI(mosi), .o_SPI_cs(spi_cs), .o_SCLK(sclk), .o_valid(strobe_valid),
        .o_continue(cont), .i_MISO(miso)
    );

    int checks = 0;
    int errors = 0;

    logic        obs_sclk  [NOBS];
    logic        obs_vld   [NOBS];
    logic        obs_rspv  [NOBS];
    logic        obs_cont  [NOBS];
    logic        obs_rdy   [NOBS];
    logic [3:0]  obs_cs    [NOBS];
    logic [24:0] obs_mosi  [NOBS];
    logic [31:0] obs_rdata [NOBS];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (req_ready !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_wait: req_ready=%b required 1", tag, req_ready);
        end
    endtask

    // Present one command, then record outputs after each of the NOBS edges following acceptance.
    task automatic do_cmd(input logic [1:0] op, input logic [3:0] cs, input logic [24:0] d);
        wait_ready("cmd");
        req_valid = 1'b1;
        req_op    = op;
        req_cs    = cs;
        req_data  = d;
        rsp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < NOBS; i++) begin
            obs_sclk[i]  = sclk;
            obs_vld[i]   = strobe_valid;
            obs_rspv[i]  = rsp_valid;
            obs_cont[i]  = cont;
            obs_rdy[i]   = req_ready;
            obs_cs[i]    = spi_cs;
            obs_mosi[i]  = mosi;
            obs_rdata[i] = rsp_data;
            step();
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({req_ready, rsp_valid, sclk, strobe_valid, cont, spi_cs, mosi, rsp_data} !== '0) begin
            errors++;
            $display("FAIL reset_init: ready=%b rspv=%b sclk=%b vld=%b cont=%b cs=%h mosi=%h data=%h required all 0",
                     req_ready, rsp_valid, sclk, strobe_valid, cont, spi_cs, mosi, rsp_data);
        end
        #10 rst_n = 1'b1;
        step();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 1", req_ready);
        end
        // Set continue so its reset clearing is observable, then reset mid-PULSE of an XFER.
        do_cmd(2'b10, 4'h0, 25'h0);
        wait_ready("reset");
        miso = 32'h0BAD_0BAD;
        req_valid = 1'b1; req_op = 2'b00; req_cs = 4'h9; req_data = 25'h0F0F0F0;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < S; i++) step();
        checks++;
        if (sclk !== 1'b1 || cont !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_pulse: sclk=%b cont=%b required 1 1", sclk, cont);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, sclk, strobe_valid, cont, spi_cs, mosi} !== '0) begin
            errors++;
            $display("FAIL reset_async: ready=%b rspv=%b sclk=%b vld=%b cont=%b cs=%h mosi=%h required all 0",
                     req_ready, rsp_valid, sclk, strobe_valid, cont, spi_cs, mosi);
        end
        #2 rst_n = 1'b1;
        step();
        checks++;
        if (req_ready !== 1'b1 || cont !== 1'b0) begin
            errors++;
            $display("FAIL reset_recover: ready=%b cont=%b required 1 0", req_ready, cont);
        end
        miso = 32'h5555_AAAA;
        do_cmd(2'b00, 4'h7, 25'h1234567);
        checks++;
        if (obs_rspv[L] !== 1'b1 || obs_rdata[L] !== 32'h5555_AAAA || obs_sclk[S] !== 1'b1) begin
            errors++;
            $display("FAIL reset_next_xfer: rspv=%b data=%h sclk=%b required 1 5555aaaa 1",
                     obs_rspv[L], obs_rdata[L], obs_sclk[S]);
        end
    endtask

    task automatic test_xfer();
        miso = 32'hDEAD_BEEF;
        do_cmd(2'b00, 4'h3, 25'h1ABCDEF);
        for (int i = 0; i < NOBS; i++) begin
            checks++;
            if (obs_sclk[i] !== (i >= S && i < S + P) || obs_vld[i] !== 1'b0) begin
                errors++;
                $display("FAIL xfer_strobe[%0d]: sclk=%b vld=%b required %b 0", i, obs_sclk[i], obs_vld[i], (i >= S && i < S + P));
            end
            checks++;
            if (obs_rspv[i] !== (i == L)) begin
                errors++;
                $display("FAIL xfer_rspv[%0d]: got %b required %b", i, obs_rspv[i], (i == L));
            end
            checks++;
            if (obs_cs[i] !== ((i <= L) ? 4'h3 : 4'h0) || obs_mosi[i] !== ((i <= L) ? 25'h1ABCDEF : 25'h0)) begin
                errors++;
                $display("FAIL xfer_bus[%0d]: cs=%h mosi=%h", i, obs_cs[i], obs_mosi[i]);
            end
        end
        checks++;
        if (obs_rdata[L] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL xfer_data: got %h required deadbeef", obs_rdata[L]);
        end
        checks++;
        if (obs_rdy[L] !== 1'b0 || obs_rdy[L + 1] !== 1'b1) begin
            errors++;
            $display("FAIL xfer_ready: at L=%b at L+1=%b required 0 1", obs_rdy[L], obs_rdy[L + 1]);
        end
    endtask

    task automatic test_step();
        miso = 32'h0000_00A5;
        do_cmd(2'b01, 4'hC, 25'h0155AA);
        for (int i = 0; i < NOBS; i++) begin
            checks++;
            if (obs_vld[i] !== (i >= S && i < S + P) || obs_sclk[i] !== 1'b0 || obs_cs[i] !== 4'h0) begin
                errors++;
                $display("FAIL step_strobe[%0d]: vld=%b sclk=%b cs=%h required %b 0 0",
                         i, obs_vld[i], obs_sclk[i], obs_cs[i], (i >= S && i < S + P));
            end
        end
        checks++;
        if (obs_mosi[S] !== 25'h0155AA || obs_rspv[L] !== 1'b1 || obs_rdata[L] !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL step_resp: mosi=%h rspv=%b data=%h required 0155aa 1 000000a5",
                     obs_mosi[S], obs_rspv[L], obs_rdata[L]);
        end
    endtask

    task automatic test_cont();
        int nresp;
        do_cmd(2'b10, 4'h0, 25'h0);
        nresp = 0;
        for (int i = 0; i < NOBS; i++) nresp += int'(obs_rspv[i]);
        checks++;
        if (obs_cont[0] !== 1'b1 || obs_rspv[H] !== 1'b1 || obs_rspv[H - 1] !== 1'b0 || nresp != 1) begin
            errors++;
            $display("FAIL cont_set: cont=%b rspv[H-1]=%b rspv[H]=%b nresp=%0d required 1 0 1 1",
                     obs_cont[0], obs_rspv[H - 1], obs_rspv[H], nresp);
        end
        do_cmd(2'b00, 4'h5, 25'h0000011);
        nresp = 0;
        for (int i = 0; i < NOBS; i++) begin
            nresp += int'(obs_rspv[i]);
            checks++;
            if (obs_cont[i] !== 1'b1) begin
                errors++;
                $display("FAIL cont_during_xfer[%0d]: got %b required 1", i, obs_cont[i]);
            end
        end
        checks++;
        if (nresp != 1) begin
            errors++;
            $display("FAIL cont_xfer_resp: nresp=%0d required 1", nresp);
        end
        do_cmd(2'b11, 4'h0, 25'h0);
        nresp = 0;
        for (int i = 0; i < NOBS; i++) nresp += int'(obs_rspv[i]);
        checks++;
        if (obs_cont[0] !== 1'b0 || obs_rspv[H] !== 1'b1 || nresp != 1 || obs_sclk[S] !== 1'b0) begin
            errors++;
            $display("FAIL cont_clr: cont=%b rspv=%b nresp=%0d sclk=%b required 0 1 1 0",
                     obs_cont[0], obs_rspv[H], nresp, obs_sclk[S]);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        wait_ready("bp");
        miso = 32'hCAFE_0001;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_op = 2'b00; req_cs = 4'h6; req_data = 25'h0000123;
        step();
        for (int i = 0; i < L; i++) step();
        miso = 32'h1111_2222;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'hCAFE_0001 || req_ready !== 1'b0 || sclk !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: rspv=%b data=%h ready=%b sclk=%b required 1 cafe0001 0 0",
                         i, rsp_valid, rsp_data, req_ready, sclk);
            end
            step();
        end
        rsp_ready = 1'b1;
        step();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_consume: rspv=%b ready=%b required 0 1", rsp_valid, req_ready);
        end
        step();
        checks++;
        if (req_ready !== 1'b0 || spi_cs !== 4'h6) begin
            errors++;
            $display("FAIL bp_next_accept: ready=%b cs=%h required 0 6", req_ready, spi_cs);
        end
        req_valid = 1'b0;
        for (int i = 0; i < S; i++) step();
        checks++;
        if (sclk !== 1'b1) begin
            errors++;
            $display("FAIL bp_next_strobe: sclk=%b required 1", sclk);
        end
        n = 0;
        while (rsp_valid !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h1111_2222) begin
            errors++;
            $display("FAIL bp_next_resp: rspv=%b data=%h required 1 11112222", rsp_valid, rsp_data);
        end
        step();
    endtask

    task automatic test_miso_timing();
        logic [31:0] exp_data;
`ifdef DBG_BUS_MASTER_MISO_SYNC_EN
        exp_data = 32'h1;
`else
        exp_data = 32'h2;
`endif
        wait_ready("miso");
        miso = 32'h1;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_op = 2'b00; req_cs = 4'h1; req_data = 25'h1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < L - 1; i++) step();
        miso = 32'h2;
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp_data) begin
            errors++;
            $display("FAIL miso_capture: rspv=%b data=%h required 1 %h", rsp_valid, rsp_data, exp_data);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_xfer();
        test_step();
        test_cont();
        test_back_to_back();
        test_miso_timing();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so a stuck DUT still ends the run with a summary.
    initial begin
        #50000;
        errors++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
